wake_wb: RTL and testbench

// Wishbone wake-source controller; generates the wake input consumed by the power manager.

---
 rtl/wake_wb_pkg.sv | 25 ++
 rtl/wake_wb_if.sv | 23 ++
 rtl/wake_wb_debounce.sv | 48 ++++
 rtl/wake_wb.sv | 166 ++++++++++++++++
 tb/tb_wake_wb.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wake_wb_pkg.sv
// Shared definitions for the wake-source controller: register map, bit positions
// and a small address-decode helper.
package wake_wb_pkg;

    // Word offsets selected by adr[3:2]
    typedef enum logic [1:0] {
        WAKE_CTRL   = 2'd0,
        WAKE_STATUS = 2'd1,
        WAKE_TIMER  = 2'd2,
        WAKE_RSVD   = 2'd3
    } reg_sel_e;

    // Bit positions inside CTRL/STATUS
    localparam int WAKE_TMR_BIT = 8;
    localparam int WAKE_PM_BIT  = 16;

    // Width of the countdown timer
    localparam int WAKE_TMR_W   = 24;

    // Map a byte address onto the register it selects
    function automatic reg_sel_e decode_reg(input logic [31:0] adr);
        return reg_sel_e'(adr[3:2]);
    endfunction

endpackage

// File: rtl/wake_wb_if.sv
// Wishbone classic slave bus bundle used by the wake controller.
interface wake_wb_if;

    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic        wb_cyc_i;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/wake_wb_debounce.sv
// One wake pin: 2-FF synchronizer, mismatch-counting debouncer and a one-cycle
// pulse whenever the accepted (stable) level goes from 0 to 1.
module wake_debounce #(
    parameter int DEB_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          meta_r;
    logic          sync_r;
    logic          stable_r;
    logic [CW-1:0] cnt_r;
    logic          rise_r;

    // Synchronize the pin, count consecutive disagreeing cycles, accept the new level
    // on the DEB_CYCLES-th one; any agreeing cycle restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r   <= 1'b0;
            sync_r   <= 1'b0;
            stable_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            rise_r   <= 1'b0;
        end else begin
            meta_r <= raw;
            sync_r <= meta_r;
            rise_r <= 1'b0;
            if (sync_r == stable_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (cnt_r == LAST) begin
                stable_r <= sync_r;
                cnt_r    <= {CW{1'b0}};
                rise_r   <= sync_r;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign rise = rise_r;

endmodule

// File: rtl/wake_wb.sv
// Wishbone wake-source controller: debounced wake pins plus a one-shot countdown
// timer latch pending events; wake_o is requested while suspended and an enabled
// event is pending, irq_o reports any pending event.
module wake_wb
    import wake_wb_pkg::*;
#(
    parameter int NSRC       = 4,
    parameter int PRESC_DIV  = 1000,
    parameter int DEB_CYCLES = 256
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wake_wb_if.slave        bus,
    input  logic [NSRC-1:0] src_i,
    input  logic            power_mode_i,
    output logic            wake_o,
    output logic            irq_o
);

    localparam int PW = (PRESC_DIV > 2) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

    // Register state; pending/enable vectors carry the timer in bit NSRC
    logic [NSRC-1:0]       en_r;
    logic                  tmr_en_r;
    logic [NSRC:0]         pend_r;
    logic [WAKE_TMR_W-1:0] count_r;
    logic [PW-1:0]         presc_r;
    logic                  pm_meta_r;
    logic                  pm_sync_r;
    logic                  wake_r;
    logic                  irq_r;

    // Combinational helpers
    logic                  wr_s;
    reg_sel_e              sel_s;
    logic                  tick_s;
    logic [NSRC-1:0]       pin_rise_s;
    logic [NSRC:0]         en_all_s;
    logic [NSRC:0]         w1c_s;
    logic [NSRC:0]         set_s;
    logic [NSRC:0]         pend_nxt_s;
    logic [WAKE_TMR_W-1:0] count_nxt_s;
    logic                  tmr_set_s;
    logic [31:0]           rd_s;
    logic                  unused_s;

    assign sel_s       = decode_reg(bus.wb_adr_i);
    assign wr_s        = bus.wb_cyc_i & bus.wb_stb_i & bus.wb_we_i;
    assign bus.wb_ack_o = bus.wb_cyc_i & bus.wb_stb_i;
    assign tick_s      = (presc_r == PRESC_LAST);
    assign en_all_s    = {tmr_en_r, en_r};
    assign unused_s    = ^{bus.wb_sel_i, bus.wb_adr_i, bus.wb_dat_i};

    genvar g;
    generate
        for (g = 0; g < NSRC; g++) begin : g_deb
            wake_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk  (wb_clk_i),
                .rst  (wb_rst_i),
                .raw  (src_i[g]),
                .rise (pin_rise_s[g])
            );
        end
    endgenerate

    // Timer next value: a TIMER write overrides any same-cycle tick; a tick
    // decrements a nonzero count and flags the 1->0 step.
    always_comb begin
        count_nxt_s = count_r;
        tmr_set_s   = 1'b0;
        if (wr_s && (sel_s == WAKE_TIMER)) begin
            count_nxt_s = bus.wb_dat_i[WAKE_TMR_W-1:0];
        end else if (tick_s && tmr_en_r && (count_r != {WAKE_TMR_W{1'b0}})) begin
            count_nxt_s = count_r - {{(WAKE_TMR_W-1){1'b0}}, 1'b1};
            tmr_set_s   = (count_r == {{(WAKE_TMR_W-1){1'b0}}, 1'b1});
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Pending update: write-one-to-clear first, then new events OR in so a set wins.
    always_comb begin
        w1c_s = {(NSRC+1){1'b0}};
        if (wr_s && (sel_s == WAKE_STATUS)) begin
            w1c_s = {bus.wb_dat_i[WAKE_TMR_BIT], bus.wb_dat_i[NSRC-1:0]};
        end else begin
            w1c_s = {(NSRC+1){1'b0}};
        end
        set_s      = {tmr_set_s, pin_rise_s & en_r};
        pend_nxt_s = (pend_r & ~w1c_s) | set_s;
    end

    // Read mux straight from the registers.
    always_comb begin
        rd_s = 32'h0000_0000;
        case (sel_s)
            WAKE_CTRL: begin
                rd_s[NSRC-1:0]     = en_r;
                rd_s[WAKE_TMR_BIT] = tmr_en_r;
            end
            WAKE_STATUS: begin
                rd_s[NSRC-1:0]     = pend_r[NSRC-1:0];
                rd_s[WAKE_TMR_BIT] = pend_r[NSRC];
                rd_s[WAKE_PM_BIT]  = pm_sync_r;
            end
            WAKE_TIMER: begin
                rd_s[WAKE_TMR_W-1:0] = count_r;
            end
            default: begin
                rd_s = 32'h0000_0000;
            end
        endcase
    end

    assign bus.wb_dat_o = rd_s;

    // Free-running prescaler; tick_s marks its wrap cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            presc_r <= {PW{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PW{1'b0}};
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Software-visible registers, timer count and pending latches.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            en_r     <= {NSRC{1'b0}};
            tmr_en_r <= 1'b0;
            pend_r   <= {(NSRC+1){1'b0}};
            count_r  <= {WAKE_TMR_W{1'b0}};
        end else begin
            if (wr_s && (sel_s == WAKE_CTRL)) begin
                en_r     <= bus.wb_dat_i[NSRC-1:0];
                tmr_en_r <= bus.wb_dat_i[WAKE_TMR_BIT];
            end
            pend_r  <= pend_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Power-mode synchronizer and registered wake/irq outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pm_meta_r <= 1'b0;
            pm_sync_r <= 1'b0;
            wake_r    <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            pm_meta_r <= power_mode_i;
            pm_sync_r <= pm_meta_r;
            wake_r    <= pm_sync_r & (|(pend_r & en_all_s));
            irq_r     <= |pend_r;
        end
    end

    assign wake_o = wake_r;
    assign irq_o  = irq_r;

endmodule

// File: tb/tb_wake_wb.sv
// Randomized scoreboard bench for wake_wb: reads queue their expected response,
// a negedge monitor pops and compares on every acknowledged read.
module tb_wake_wb;

    localparam int NSRC  = 4;
    localparam int PRESC = 4;
    localparam int DEB   = 256;

    localparam logic [31:0] A_CTRL = 32'h0;
    localparam logic [31:0] A_STAT = 32'h4;
    localparam logic [31:0] A_TMR  = 32'h8;
    localparam logic [31:0] A_RSVD = 32'hC;

    logic            clk = 1'b0;
    logic            rst;
    logic [NSRC-1:0] src;
    logic            pm;
    logic            wake;
    logic            irq;

    wake_wb_if bus();

    always #5 clk = ~clk;

    wake_wb #(.NSRC(NSRC), .PRESC_DIV(PRESC), .DEB_CYCLES(DEB)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .bus          (bus),
        .src_i        (src),
        .power_mode_i (pm),
        .wake_o       (wake),
        .irq_o        (irq)
    );

    typedef struct {
        string       name;
        logic [31:0] dat;
        logic [31:0] mask;
        bit          lines;
        bit          wake;
        bit          irq;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Monitor: every acknowledged read with an outstanding expectation is compared
    always @(negedge clk) begin
        if (bus.wb_cyc_i && bus.wb_stb_i && !bus.wb_we_i && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (bus.wb_ack_o !== 1'b1) begin
                errors++;
                $display("FAIL %s ack got %b want 1", e.name, bus.wb_ack_o);
            end
            checks++;
            if ((bus.wb_dat_o & e.mask) !== (e.dat & e.mask)) begin
                errors++;
                $display("FAIL %s data got %h want %h (mask %h)", e.name,
                         bus.wb_dat_o & e.mask, e.dat & e.mask, e.mask);
            end
            if (e.lines) begin
                checks++;
                if ({wake, irq} !== {e.wake, e.irq}) begin
                    errors++;
                    $display("FAIL %s wake/irq got %b%b want %b%b", e.name, wake, irq, e.wake, e.irq);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic idle_bus();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.wb_adr_i = a; bus.wb_dat_i = d; bus.wb_we_i = 1'b1;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic rd_chk(input string n, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] m, input bit lines, input bit w, input bit i);
        exp_t e;
        e.name = n; e.dat = d; e.mask = m; e.lines = lines; e.wake = w; e.irq = i;
        q.push_back(e);
        @(posedge clk); #1;
        bus.wb_adr_i = a; bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        @(negedge clk); #1;
        idle_bus();
    endtask

    // Write, then read the same register in the very next cycle
    task automatic wr_rd_chk(input string n, input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] want);
        exp_t e;
        @(posedge clk); #1;
        bus.wb_adr_i = a; bus.wb_dat_i = d; bus.wb_we_i = 1'b1;
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        @(posedge clk); #1;
        e.name = n; e.dat = want; e.mask = 32'hFFFF_FFFF; e.lines = 1'b0; e.wake = 1'b0; e.irq = 1'b0;
        q.push_back(e);
        bus.wb_we_i = 1'b0;
        @(negedge clk); #1;
        idle_bus();
    endtask

    task automatic rd_raw(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus.wb_adr_i = a; bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        @(negedge clk);
        d = bus.wb_dat_o;
        #1;
        idle_bus();
    endtask

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, got, want);
        end
    endtask

    // Hold a pin high for len cycles, then let the debouncer settle back low
    task automatic pulse(input int idx, input int len);
        @(posedge clk); #1;
        src[idx] = 1'b1;
        repeat (len) @(posedge clk);
        #1;
        src[idx] = 1'b0;
        repeat (DEB + 20) @(posedge clk);
    endtask

    initial begin
        logic [31:0] d;
        int          k;
        bit          found;

        rst = 1'b1; src = '0; pm = 1'b0;
        bus.wb_adr_i = 32'h0; bus.wb_dat_i = 32'h0; bus.wb_sel_i = 4'hF;
        idle_bus();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        rd_chk("rst_ctrl",   A_CTRL, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        rd_chk("rst_status", A_STAT, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        rd_chk("rst_timer",  A_TMR,  32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

        // Debounce: short glitch rejected, long hold accepted
        wr(A_CTRL, 32'h1);
        pulse(0, 100);
        rd_chk("deb_glitch", A_STAT, 32'h0, 32'h1_01FF, 1'b1, 1'b0, 1'b0);
        pulse(0, 300);
        rd_chk("deb_hold", A_STAT, 32'h1, 32'h1_01FF, 1'b1, 1'b0, 1'b1);
        wr(A_STAT, 32'h1FF);

        // Disabled pin and reserved register
        wr(A_CTRL, 32'h0);
        pulse(1, 1000);
        rd_chk("disabled_pin", A_STAT, 32'h0, 32'h1_01FF, 1'b1, 1'b0, 1'b0);
        wr(A_RSVD, 32'hFFFF_FFFF);
        rd_chk("rsvd_read", A_RSVD, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        rd_chk("rsvd_no_alias", A_CTRL, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // W1C race: find the edge at which a pin event lands, then clear on that edge
        wr(A_CTRL, 32'h1);
        @(posedge clk); #1;
        bus.wb_adr_i = A_STAT; bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
        src[0] = 1'b1;
        k = 0; found = 1'b0;
        while (!found && k < 2 * DEB) begin
            @(negedge clk);
            if (bus.wb_dat_o[0] === 1'b1) found = 1'b1;
            else k++;
        end
        #1;
        idle_bus();
        checks++;
        if (!found || k < 1) begin
            errors++;
            $display("FAIL race_calib edge got %0d want pending within %0d cycles", k, 2 * DEB);
        end
        @(posedge clk); #1 src[0] = 1'b0;
        repeat (DEB + 20) @(posedge clk);
        wr(A_STAT, 32'h1);
        if (found && k >= 1) begin
            @(posedge clk); #1;
            src[0] = 1'b1;
            repeat (k - 1) @(posedge clk);
            #1;
            bus.wb_adr_i = A_STAT; bus.wb_dat_i = 32'h1; bus.wb_we_i = 1'b1;
            bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
            @(posedge clk); #1;
            idle_bus();
            rd_chk("w1c_race_set_wins", A_STAT, 32'h1, 32'h1FF, 1'b0, 1'b0, 1'b0);
            wr(A_STAT, 32'h1);
            rd_chk("w1c_second_clear", A_STAT, 32'h0, 32'h1FF, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1 src[0] = 1'b0;
            repeat (DEB + 20) @(posedge clk);
        end

        // Randomized pin pulses and timer loads, judged by the debounce/one-shot rules
        for (int it = 0; it < 6; it++) begin
            int          idx;
            int          len;
            int          tv;
            bit          lng;
            logic [3:0]  msk;
            logic [31:0] exp_st;
            idx = $urandom_range(0, NSRC - 1);
            msk = 4'($urandom_range(0, 15));
            lng = 1'($urandom_range(0, 1));
            len = lng ? $urandom_range(DEB + 12, DEB + 150) : $urandom_range(5, DEB - 12);
            tv  = $urandom_range(1, 6);
            wr(A_CTRL, {23'h0, 1'b1, 4'h0, msk});
            wr_rd_chk("rnd_timer_load", A_TMR, 32'(tv), 32'(tv));
            pulse(idx, len);
            exp_st = 32'h100;
            if (lng && msk[idx]) exp_st = exp_st | (32'h1 << idx);
            rd_chk("rnd_status", A_STAT, exp_st, 32'h1_01FF, 1'b1, 1'b0, 1'b1);
            rd_chk("rnd_timer_done", A_TMR, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
            wr(A_CTRL, 32'h0);
            rd_chk("rnd_en_clear_keeps", A_STAT, exp_st, 32'h1FF, 1'b0, 1'b0, 1'b0);
            wr(A_STAT, 32'h1FF);
            rd_chk("rnd_w1c_all", A_STAT, 32'h0, 32'h1FF, 1'b1, 1'b0, 1'b0);
        end

        // Timer wake while suspended
        @(posedge clk); #1 pm = 1'b1;
        repeat (5) @(posedge clk);
        wr(A_CTRL, 32'h100);
        wr_rd_chk("tmr_load5", A_TMR, 32'h5, 32'h5);
        k = 0; found = 1'b0;
        while (!found && k < 40) begin
            k++;
            rd_raw(A_STAT, d);
            if (d[8] === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || k < 4 * PRESC + 1 || k > 5 * PRESC) begin
            errors++;
            $display("FAIL tmr_latency got %0d cycles want %0d..%0d", k, 4 * PRESC + 1, 5 * PRESC);
        end
        chk("tmr_wake_lag", {31'h0, wake}, 32'h0);
        chk("tmr_irq_lag",  {31'h0, irq},  32'h0);
        rd_chk("tmr_wake_on", A_STAT, 32'h1_0100, 32'h1_01FF, 1'b1, 1'b1, 1'b1);

        // Wake hold: drops exactly 3 cycles after resume
        @(posedge clk); #1 pm = 1'b0;
        rd_chk("hold_c1", A_STAT, 32'h100, 32'h1FF, 1'b1, 1'b1, 1'b1);
        rd_chk("hold_c2", A_STAT, 32'h100, 32'h1FF, 1'b1, 1'b1, 1'b1);
        rd_chk("hold_c3", A_STAT, 32'h100, 32'h1_01FF, 1'b1, 1'b0, 1'b1);

        // Still pending from active mode: wake reasserts 1 cycle after pm_sync rises
        @(posedge clk); #1 pm = 1'b1;
        rd_chk("resus_c1", A_STAT, 32'h100, 32'h1FF, 1'b1, 1'b0, 1'b1);
        rd_chk("resus_c2", A_STAT, 32'h1_0100, 32'h1_01FF, 1'b1, 1'b0, 1'b1);
        rd_chk("resus_c3", A_STAT, 32'h1_0100, 32'h1_01FF, 1'b1, 1'b1, 1'b1);

        // Reset mid-count / mid-debounce discards everything
        wr(A_TMR, 32'd100);
        @(posedge clk); #1 src[2] = 1'b1;
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        rd_chk("midrst_status", A_STAT, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        rd_chk("midrst_timer",  A_TMR,  32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        rd_chk("midrst_ctrl",   A_CTRL, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0; src = '0; pm = 1'b0;

        repeat (5) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
